// File: rtl/event_pulse_emitter_if.sv
// Bus between a pipeline stage's event logic and the pulse emitter.
// The master supplies events and clear; the slave returns the pulse stream and status.
interface event_pulse_emitter_if #(
  parameter int width = 16,
  parameter int IN_W  = 2
);
  logic [IN_W-1:0]  event_count;
  logic             clear;
  logic             increment;
  logic [width-1:0] pending;
  logic             busy;
  logic             overflow;

  modport master (
    output event_count, clear,
    input  increment, pending, busy, overflow
  );

  modport slave (
    input  event_count, clear,
    output increment, pending, busy, overflow
  );
endinterface

// File: rtl/event_pulse_emitter.sv
// Queues per-cycle event counts in a saturating backlog and replays them as
// well-formed increment pulses (high HIGH_CYCLES, low at least GAP_CYCLES).
//
// state | meaning
// IDLE  | no pulse in flight; launches as soon as the backlog is non-zero
// HIGH  | increment held high, phase counts down the remaining high cycles
// GAP   | increment low, phase counts down the remaining gap cycles
module event_pulse_emitter #(
  parameter int width       = 16,
  parameter int IN_W        = 2,
  parameter int HIGH_CYCLES = 1,
  parameter int GAP_CYCLES  = 1
) (
  input logic                  clk,
  input logic                  reset,
  event_pulse_emitter_if.slave bus
);

  localparam int PH_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);
  localparam int SUM_W  = width + IN_W + 1;
  localparam logic [SUM_W-1:0] PEND_MAX = (SUM_W'(1) << width) - SUM_W'(1);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t           state, state_nxt;
  logic [PH_W-1:0]  phase, phase_nxt;
  logic [width-1:0] pending_q, pending_nxt;
  logic             overflow_q, overflow_nxt;
  logic             increment_q;
  logic             launch;
  logic [SUM_W-1:0] sum;

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    launch       = 1'b0;
    pending_nxt  = pending_q;
    overflow_nxt = overflow_q;
    sum          = '0;

    unique case (state)
      IDLE: launch = (pending_q != '0);
      HIGH: begin
        if (phase == '0) begin
          state_nxt = GAP;
          phase_nxt = PH_W'(GAP_CYCLES - 1);
        end else begin
          phase_nxt = phase - PH_W'(1);
        end
      end
      GAP: begin
        if (phase == '0) begin
          if (pending_q != '0) launch = 1'b1;
          else                 state_nxt = IDLE;
        end else begin
          phase_nxt = phase - PH_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (launch) begin
      state_nxt = HIGH;
      phase_nxt = PH_W'(HIGH_CYCLES - 1);
    end

    // launch only happens with a non-zero backlog, so the sum never underflows
    sum = SUM_W'(pending_q) + SUM_W'(bus.event_count) - SUM_W'(launch);
    if (sum > PEND_MAX) begin
      pending_nxt  = '1;
      overflow_nxt = 1'b1;
    end else begin
      pending_nxt  = sum[width-1:0];
    end

    if (bus.clear) begin
      state_nxt    = IDLE;
      phase_nxt    = '0;
      pending_nxt  = '0;
      overflow_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      phase       <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      increment_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      pending_q   <= pending_nxt;
      overflow_q  <= overflow_nxt;
      increment_q <= (state_nxt == HIGH);
    end
  end

  assign bus.increment = increment_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state != IDLE) || (pending_q != '0);

endmodule
